adc_sample_sequencer: RTL and testbench
=======================================

ADC_SAMPLE_SEQUENCER -- requirements
Module: adc_sample_sequencer

Interface
REQ-001 Parameter SOC_PERIOD, default 2200; CLK cycles between SOC pulses.
REQ-002 Parameter AVG_LOG2, default 2; average window of 2^AVG_LOG2 samples (legal 0..4).
REQ-003 Parameter TIMEOUT, default 255; maximum wait in cycles for EOC or DRDY.
REQ-004 CLK  input  1  single clock for all logic; rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 EN  input  1  enables periodic conversion scheduling.
REQ-007 CLR_ERR  input  1  one-cycle clear of the sticky error flags.
REQ-008 CHANNEL  input  5  current ADC channel reported by the converter.
REQ-009 EOC  input  1  end-of-conversion pulse from the converter.
REQ-010 DRDY  input  1  DRP read-data-ready pulse.
REQ-011 DO  input  16  DRP read data; result in DO[15:4].
REQ-012 SOC  output  1  one-cycle start-of-conversion pulse.
REQ-013 DEN  output  1  one-cycle DRP read enable.
REQ-014 DADDR  output  7  DRP address, {2'b00, channel latched at EOC}.
REQ-015 SAMPLE  output  12  last raw sample; SAMPLE_VALID  output  1  one-cycle strobe.
REQ-016 AVG  output  12  windowed average; AVG_VALID  output  1  one-cycle strobe.
REQ-017 BUSY  output  1  high in any state other than IDLE.
REQ-018 TO_ERR  output  1  sticky timeout flag; OVR_ERR  output  1  sticky overrun flag.

Function
REQ-019 States SHALL be IDLE, CONVERT, READ, UPDATE; encoded as a registered FSM.
REQ-020 Period counter SHALL count 0..SOC_PERIOD-1 while EN=1, wrap to 0, and be held at 0 while EN=0.
REQ-021 A tick SHALL occur on the cycle the counter equals SOC_PERIOD-1 with EN=1.
REQ-022 Tick in IDLE: SOC=1 on the next cycle, FSM enters CONVERT, wait counter cleared.
REQ-023 Tick in any other state: no SOC, OVR_ERR set, current transaction unaffected.
REQ-024 CONVERT: on EOC=1, latch CHANNEL, enter READ; next cycle DEN=1 for exactly one cycle with DADDR valid.
REQ-025 READ: on DRDY=1, capture DO[15:4] into SAMPLE, enter UPDATE; DRDY outside READ SHALL be ignored.
REQ-026 UPDATE (one cycle): SAMPLE_VALID=1, accumulator += SAMPLE, sample count incremented, return to IDLE.
REQ-027 Accumulator width SHALL be 12+AVG_LOG2 bits; no overflow possible.
REQ-028 When the count reaches 2^AVG_LOG2 in UPDATE: AVG = (acc + SAMPLE) >> AVG_LOG2 registered, AVG_VALID=1 in the same cycle as SAMPLE_VALID, accumulator and count cleared.
REQ-029 AVG_LOG2=0: AVG SHALL equal SAMPLE on every update.
REQ-030 Wait counter SHALL count cycles in CONVERT and READ; reaching TIMEOUT without the awaited pulse: TO_ERR set, FSM to IDLE, accumulator and count unchanged, no strobes.
REQ-031 EOC or DRDY arriving on the same cycle the wait counter reaches TIMEOUT SHALL be accepted (no timeout).
REQ-032 EN deassertion mid-transaction SHALL NOT abort it; the FSM completes to IDLE and issues no further SOC.
REQ-033 CLR_ERR SHALL clear TO_ERR and OVR_ERR; a simultaneous set event SHALL win.
REQ-034 Latency: tick to SOC 1 cycle; EOC to DEN 1 cycle; DRDY to SAMPLE_VALID 1 cycle.

Reset
REQ-035 RESET=1 SHALL force IDLE and zero the period, wait and sample counters, the accumulator, SAMPLE, AVG, DADDR, all strobes, BUSY, TO_ERR and OVR_ERR on the next edge.
REQ-036 RESET SHALL take priority over every other input including mid-transaction handshakes.

Verification (SOC_PERIOD=100, AVG_LOG2=2, TIMEOUT=50)
REQ-037 EN=1, EOC 10 cycles after SOC, DRDY 3 cycles after DEN, DO=16'hABC0 -> SOC every 100 cycles, DADDR={2'b00,CHANNEL}, SAMPLE=12'hABC with one-cycle SAMPLE_VALID.
REQ-038 Four samples 12'h100, 12'h200, 12'h300, 12'h401 -> AVG_VALID once, AVG=12'h280, then the accumulator restarts.
REQ-039 No EOC after SOC -> TO_ERR=1 at 50 cycles, BUSY=0; next tick issues SOC normally; CLR_ERR clears TO_ERR.
REQ-040 DRDY withheld for 150 cycles with TIMEOUT=200 -> tick at 100 cycles sets OVR_ERR with no extra SOC; the sample still completes.
REQ-041 RESET asserted between DEN and DRDY -> all outputs zero the next cycle; the late DRDY is ignored; the average window restarts from zero.
REQ-042 EN dropped during CONVERT -> transaction completes, SAMPLE_VALID pulses, then no SOC while EN=0.

Source files
------------

// File: rtl/adc_sample_sequencer.sv
// Periodic ADC sample sequencer: issues SOC, waits for EOC, reads the result over DRP,
// and maintains a 2^AVG_LOG2-sample windowed average with sticky timeout/overrun flags.
module adc_sample_sequencer #(
  parameter int unsigned SOC_PERIOD = 2200,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        EN,
  input  logic        CLR_ERR,
  input  logic [4:0]  CHANNEL,
  input  logic        EOC,
  input  logic        DRDY,
  input  logic [15:0] DO,
  output logic        SOC,
  output logic        DEN,
  output logic [6:0]  DADDR,
  output logic [11:0] SAMPLE,
  output logic        SAMPLE_VALID,
  output logic [11:0] AVG,
  output logic        AVG_VALID,
  output logic        BUSY,
  output logic        TO_ERR,
  output logic        OVR_ERR
);

  localparam int unsigned PW    = (SOC_PERIOD > 1) ? $clog2(SOC_PERIOD) : 1;
  localparam int unsigned WW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned AW    = 12 + AVG_LOG2;
  localparam int unsigned CW    = AVG_LOG2 + 1;
  localparam int unsigned AVG_N = 1 << AVG_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    READ,
    UPDATE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] period_cnt;
  logic          tick;
  logic [WW-1:0] wait_cnt;
  logic          wait_at_limit;
  logic          soc_next;
  logic          den_next;
  logic          take_eoc;
  logic          take_drdy;
  logic          timeout;
  logic          window_full;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [AW-1:0] avg_sum;
  logic [AW-1:0] avg_shift;
  logic          unused_lsb;

  assign unused_lsb    = ^DO[3:0];
  assign tick          = EN && (period_cnt == PW'(SOC_PERIOD - 1));
  assign wait_at_limit = (wait_cnt == WW'(TIMEOUT));
  assign window_full   = (cnt == CW'(AVG_N - 1));
  assign avg_sum       = acc + AW'(DO[15:4]);
  assign avg_shift     = avg_sum >> AVG_LOG2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    soc_next     = 1'b0;
    den_next     = 1'b0;
    take_eoc     = 1'b0;
    take_drdy    = 1'b0;
    timeout      = 1'b0;
    BUSY         = (state != IDLE);
    SAMPLE_VALID = (state == UPDATE);
    AVG_VALID    = (state == UPDATE) && window_full;
    case (state)
      IDLE: begin
        if (tick) begin
          state_next = CONVERT;
          soc_next   = 1'b1;
        end
      end
      CONVERT: begin
        // The awaited pulse wins over a timeout landing on the same cycle.
        if (EOC) begin
          take_eoc   = 1'b1;
          den_next   = 1'b1;
          state_next = READ;
        end else if (wait_at_limit) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      READ: begin
        if (DRDY) begin
          take_drdy  = 1'b1;
          state_next = UPDATE;
        end else if (wait_at_limit) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      UPDATE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET || !EN || tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // Restarts from zero on entry to CONVERT (from IDLE) and on entry to READ.
  always_ff @(posedge CLK) begin
    if (RESET || state == IDLE || state == UPDATE || take_eoc) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      SOC     <= 1'b0;
      DEN     <= 1'b0;
      DADDR   <= '0;
      SAMPLE  <= '0;
      AVG     <= '0;
      acc     <= '0;
      cnt     <= '0;
      TO_ERR  <= 1'b0;
      OVR_ERR <= 1'b0;
    end else begin
      SOC <= soc_next;
      DEN <= den_next;
      if (take_eoc) begin
        DADDR <= {2'b00, CHANNEL};
      end
      // AVG is registered alongside SAMPLE so both strobes share the UPDATE cycle.
      if (take_drdy) begin
        SAMPLE <= DO[15:4];
        if (window_full) begin
          AVG <= avg_shift[11:0];
        end
      end
      if (state == UPDATE) begin
        if (window_full) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= acc + AW'(SAMPLE);
          cnt <= cnt + 1'b1;
        end
      end
      TO_ERR  <= timeout | (TO_ERR & ~CLR_ERR);
      OVR_ERR <= (tick && state != IDLE) | (OVR_ERR & ~CLR_ERR);
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed/random bench for adc_sample_sequencer; expectations come from a window-queue
// model and cycle arithmetic on the SOC period and timeout budget.
module tb_adc_sample_sequencer;

  localparam int P   = 100;
  localparam int TO  = 50;
  localparam int WIN = 4;

  logic        CLK = 1'b0;
  logic        RESET, EN, CLR_ERR, EOC, DRDY;
  logic [4:0]  CHANNEL;
  logic [15:0] do_data;
  logic        SOC, DEN, SAMPLE_VALID, AVG_VALID, BUSY, TO_ERR, OVR_ERR;
  logic [6:0]  DADDR;
  logic [11:0] SAMPLE, AVG;

  int          cyc = 0;
  int          last_soc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [11:0] win[$];
  logic [11:0] model_avg = '0;

  adc_sample_sequencer #(.SOC_PERIOD(P), .AVG_LOG2(2), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .CLR_ERR(CLR_ERR), .CHANNEL(CHANNEL),
    .EOC(EOC), .DRDY(DRDY), .DO(do_data), .SOC(SOC), .DEN(DEN), .DADDR(DADDR),
    .SAMPLE(SAMPLE), .SAMPLE_VALID(SAMPLE_VALID), .AVG(AVG), .AVG_VALID(AVG_VALID),
    .BUSY(BUSY), .TO_ERR(TO_ERR), .OVR_ERR(OVR_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_soc(input int gap);
    int n;
    n = 0;
    while (SOC !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    chk("soc_seen", {31'd0, SOC}, 32'd1);
    if (gap > 0) chk("soc_gap", cyc - last_soc, gap);
    last_soc = cyc;
  endtask

  task automatic finish_drdy(input logic [15:0] d, input logic [4:0] ch);
    logic [11:0] v;
    int unsigned sum;
    logic        av;
    v = d[15:4];
    DRDY = 1'b1;
    do_data = d;
    step();
    DRDY = 1'b0;
    do_data = 16'($urandom);
    win.push_back(v);
    av = 1'b0;
    if (win.size() == WIN) begin
      sum = 0;
      foreach (win[i]) sum += int'(win[i]);
      model_avg = 12'(sum / WIN);
      av = 1'b1;
      win.delete();
    end
    chk("sample_valid", {31'd0, SAMPLE_VALID}, 32'd1);
    chk("sample", {20'd0, SAMPLE}, {20'd0, v});
    chk("avg_valid", {31'd0, AVG_VALID}, {31'd0, av});
    chk("avg", {20'd0, AVG}, {20'd0, model_avg});
    chk("daddr_hold", {25'd0, DADDR}, {25'd0, 2'b00, ch});
    step();
    chk("sample_valid_once", {31'd0, SAMPLE_VALID}, 32'd0);
    chk("avg_valid_once", {31'd0, AVG_VALID}, 32'd0);
    chk("busy_done", {31'd0, BUSY}, 32'd0);
  endtask

  task automatic run_txn(input int eoc_d, input int drdy_d, input logic [15:0] d,
                         input logic [4:0] ch);
    repeat (eoc_d) step();
    EOC = 1'b1;
    CHANNEL = ch;
    step();
    EOC = 1'b0;
    CHANNEL = 5'($urandom);
    chk("soc_once", {31'd0, SOC}, 32'd0);
    chk("den", {31'd0, DEN}, 32'd1);
    chk("daddr", {25'd0, DADDR}, {25'd0, 2'b00, ch});
    chk("busy", {31'd0, BUSY}, 32'd1);
    if (drdy_d > 0) begin
      step();
      chk("den_once", {31'd0, DEN}, 32'd0);
      repeat (drdy_d - 1) step();
    end
    finish_drdy(d, ch);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_soc"}, {31'd0, SOC}, 32'd0);
    chk({tag, "_den"}, {31'd0, DEN}, 32'd0);
    chk({tag, "_daddr"}, {25'd0, DADDR}, 32'd0);
    chk({tag, "_sample"}, {20'd0, SAMPLE}, 32'd0);
    chk({tag, "_sv"}, {31'd0, SAMPLE_VALID}, 32'd0);
    chk({tag, "_avg"}, {20'd0, AVG}, 32'd0);
    chk({tag, "_av"}, {31'd0, AVG_VALID}, 32'd0);
    chk({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
    chk({tag, "_to"}, {31'd0, TO_ERR}, 32'd0);
    chk({tag, "_ovr"}, {31'd0, OVR_ERR}, 32'd0);
  endtask

  initial begin
    int s;
    int n;
    logic [15:0] samples[4];
    samples = '{16'h1000, 16'h2000, 16'h3000, 16'h4010};

    RESET = 1'b1; EN = 1'b0; CLR_ERR = 1'b0; EOC = 1'b0; DRDY = 1'b0;
    CHANNEL = '0; do_data = '0;
    repeat (3) step();
    chk_all_zero("reset");
    RESET = 1'b0;
    step();

    // Four fixed samples close one averaging window.
    EN = 1'b1;
    last_soc = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_soc(P);
      run_txn(10, 3, samples[i], 5'(i + 3));
    end
    chk("avg_280", {20'd0, AVG}, 32'h280);

    wait_soc(P);
    run_txn(10, 3, 16'hABC0, 5'd17);
    chk("sample_abc", {20'd0, SAMPLE}, 32'hABC);

    for (int i = 0; i < 7; i++) begin
      wait_soc(P);
      run_txn(int'($urandom_range(0, 20)), int'($urandom_range(0, 10)),
              16'($urandom), 5'($urandom));
    end

    // Converter never answers: timeout after the full wait budget.
    wait_soc(P);
    s = cyc;
    repeat (TO) step();
    chk("to_not_yet", {31'd0, TO_ERR}, 32'd0);
    chk("to_busy", {31'd0, BUSY}, 32'd1);
    step();
    chk("to_err_set", {31'd0, TO_ERR}, 32'd1);
    chk("to_idle", {31'd0, BUSY}, 32'd0);
    chk("to_no_sv", {31'd0, SAMPLE_VALID}, 32'd0);
    wait_soc(P);
    chk("to_soc_gap", cyc - s, P);
    run_txn(4, 2, 16'($urandom), 5'($urandom));
    chk("to_sticky", {31'd0, TO_ERR}, 32'd1);
    CLR_ERR = 1'b1;
    step();
    CLR_ERR = 1'b0;
    chk("to_cleared", {31'd0, TO_ERR}, 32'd0);

    // EOC and DRDY on the last allowed wait cycle; next tick lands mid-READ.
    wait_soc(P);
    s = cyc;
    repeat (TO) step();
    EOC = 1'b1;
    CHANNEL = 5'd9;
    step();
    EOC = 1'b0;
    chk("late_eoc_den", {31'd0, DEN}, 32'd1);
    repeat (P - 1 - (cyc - s)) step();
    chk("ovr_before", {31'd0, OVR_ERR}, 32'd0);
    CLR_ERR = 1'b1;
    step();
    CLR_ERR = 1'b0;
    chk("ovr_set_wins", {31'd0, OVR_ERR}, 32'd1);
    chk("ovr_busy", {31'd0, BUSY}, 32'd1);
    chk("ovr_no_soc", {31'd0, SOC}, 32'd0);
    step();
    chk("read_limit_busy", {31'd0, BUSY}, 32'd1);
    finish_drdy(16'($urandom), 5'd9);
    chk("ovr_no_to", {31'd0, TO_ERR}, 32'd0);
    wait_soc(2 * P);

    // EN dropped mid-transaction.
    EN = 1'b0;
    run_txn(5, 2, 16'($urandom), 5'($urandom));
    n = 0;
    repeat (250) begin
      step();
      if (SOC === 1'b1) n++;
    end
    chk("no_soc_en0", n, 0);
    EN = 1'b1;
    last_soc = cyc;
    wait_soc(P);
    run_txn(7, 1, 16'($urandom), 5'($urandom));

    // Reset between DEN and DRDY.
    wait_soc(P);
    run_txn(2, 1, 16'($urandom), 5'($urandom));
    wait_soc(P);
    repeat (3) step();
    EOC = 1'b1;
    CHANNEL = 5'd21;
    step();
    EOC = 1'b0;
    chk("pre_rst_den", {31'd0, DEN}, 32'd1);
    chk("pre_rst_ovr", {31'd0, OVR_ERR}, 32'd1);
    step();
    RESET = 1'b1;
    last_soc = cyc;
    step();
    RESET = 1'b0;
    win.delete();
    model_avg = '0;
    chk_all_zero("midrst");
    DRDY = 1'b1;
    do_data = 16'hFFF0;
    step();
    DRDY = 1'b0;
    chk("late_drdy_sv", {31'd0, SAMPLE_VALID}, 32'd0);
    chk("late_drdy_sample", {20'd0, SAMPLE}, 32'd0);
    chk("late_drdy_busy", {31'd0, BUSY}, 32'd0);
    wait_soc(P + 1);
    run_txn(int'($urandom_range(0, 20)), int'($urandom_range(0, 10)),
            16'($urandom), 5'($urandom));
    for (int i = 0; i < 3; i++) begin
      wait_soc(P);
      run_txn(int'($urandom_range(0, 20)), int'($urandom_range(0, 10)),
              16'($urandom), 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
